// File: rtl/move_sequencer.sv
// Sequences a chess move: pick up an own piece, wait for its legal-move mask,
// accept a destination or a cancel, then put the piece down on the board.
module move_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        click,
  input  logic [5:0]  click_pos,
  input  logic [3:0]  sq_code,
  input  logic        moves_valid,
  input  logic [63:0] possible_moves,
  input  logic        game_over,
  output logic        pick_piece,
  output logic        place_piece,
  output logic [5:0]  figure_position,
  output logic        moves_req,
  output logic [5:0]  src_pos,
  output logic        turn,
  output logic        holding,
  output logic        illegal,
  output logic [9:0]  move_count
);

  typedef enum logic [2:0] {
    IDLE, PICK, WAIT_MOVES, HOLD, PLACE, SETTLE, OVER
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  wdog;
  logic [63:0] mask;
  logic        commit;
  logic        own, hit_src, hit_mask, wd_expire;

  assign own       = turn ? (sq_code >= 4'd7 && sq_code <= 4'd12)
                          : (sq_code >= 4'd1 && sq_code <= 4'd6);
  assign hit_src   = (click_pos == src_pos);
  assign hit_mask  = mask[click_pos];
  // Leave on the cycle the count would reach 255, so PLACE lands 255 cycles after entry.
  assign wd_expire = (wdog == 8'd254);

  assign pick_piece  = (state == PICK);
  assign moves_req   = (state == PICK);
  assign place_piece = (state == PLACE);
  assign holding     = (state == WAIT_MOVES) || (state == HOLD);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (game_over)                          state_nx = OVER;
                  else if (click && own)                  state_nx = PICK;
      PICK:                                               state_nx = WAIT_MOVES;
      WAIT_MOVES: if (moves_valid)                        state_nx = HOLD;
                  else if (wd_expire)                     state_nx = PLACE;
      HOLD:       if (click && (hit_src || hit_mask))     state_nx = PLACE;
      PLACE:                                              state_nx = SETTLE;
      SETTLE:     state_nx = game_over ? OVER : IDLE;
      OVER:                                               state_nx = OVER;
      default:                                            state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_pos         <= '0;
      figure_position <= '0;
      turn            <= 1'b0;
      move_count      <= '0;
      wdog            <= '0;
      mask            <= '0;
      commit          <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: if (!game_over && click && own) begin
          src_pos         <= click_pos;
          figure_position <= click_pos;
        end
        PICK: wdog <= '0;
        WAIT_MOVES: begin
          if (moves_valid) mask <= possible_moves;
          else if (wd_expire) begin
            figure_position <= src_pos;
            commit          <= 1'b0;
          end else wdog <= wdog + 8'd1;
        end
        HOLD: if (click) begin
          if (hit_src) begin
            figure_position <= src_pos;
            commit          <= 1'b0;
          end else if (hit_mask) begin
            figure_position <= click_pos;
            commit          <= 1'b1;
          end else illegal <= 1'b1;
        end
        PLACE: if (commit) begin
          turn <= ~turn;
          if (move_count != 10'd1023) move_count <= move_count + 10'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed move scenarios plus randomized play,
// with a timestamp-based model of the expected pulses and registers.
module tb_move_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        click = 1'b0, moves_valid = 1'b0, game_over = 1'b0;
  logic [5:0]  click_pos = '0;
  logic [3:0]  sq_code = '0;
  logic [63:0] possible_moves = '0;
  logic        pick_piece, place_piece, moves_req, turn, holding, illegal;
  logic [5:0]  figure_position, src_pos;
  logic [9:0]  move_count;

  int checks = 0, errors = 0;

  move_sequencer dut (
    .clk(clk), .rst(rst), .click(click), .click_pos(click_pos), .sq_code(sq_code),
    .moves_valid(moves_valid), .possible_moves(possible_moves), .game_over(game_over),
    .pick_piece(pick_piece), .place_piece(place_piece), .figure_position(figure_position),
    .moves_req(moves_req), .src_pos(src_pos), .turn(turn), .holding(holding),
    .illegal(illegal), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (cycle timestamps) ----------------
  int          cyc = 0;
  int          pick_at = -10, place_at = -10, ill_at = -10, wait_entry = 0;
  bit          lifted = 0, have_mask = 0, m_commit = 0, over = 0, m_turn = 0;
  int          m_cnt = 0;
  logic [5:0]  m_src = '0, m_fig = '0;
  logic [63:0] m_mask = '0;

  function automatic bit own_piece(input bit t, input logic [3:0] c);
    return t ? (c >= 7 && c <= 12) : (c >= 1 && c <= 6);
  endfunction

  task automatic model_reset();
    pick_at = -10; place_at = -10; ill_at = -10; wait_entry = 0;
    lifted = 0; have_mask = 0; m_commit = 0; over = 0; m_turn = 0; m_cnt = 0;
    m_src = '0; m_fig = '0; m_mask = '0;
  endtask

  task automatic model_step();
    int prev;
    prev = cyc;
    cyc++;
    if (over) return;
    if (prev == place_at) begin
      if (m_commit) begin
        m_turn = !m_turn;
        if (m_cnt < 1023) m_cnt++;
      end
    end else if (prev == place_at + 1) begin
      if (game_over) over = 1;
    end else if (!lifted) begin
      if (game_over) over = 1;
      else if (click && own_piece(m_turn, sq_code)) begin
        m_src = click_pos; m_fig = click_pos; pick_at = cyc;
        lifted = 1; have_mask = 0; wait_entry = cyc + 1;
      end
    end else if (!have_mask) begin
      if (prev >= wait_entry) begin
        if (moves_valid) begin
          m_mask = possible_moves; have_mask = 1;
        end else if (prev - wait_entry == 254) begin
          m_fig = m_src; m_commit = 0; place_at = cyc; lifted = 0;
        end
      end
    end else if (click) begin
      if (click_pos == m_src) begin
        m_fig = m_src; m_commit = 0; place_at = cyc; lifted = 0;
      end else if (m_mask[click_pos]) begin
        m_fig = click_pos; m_commit = 1; place_at = cyc; lifted = 0;
      end else ill_at = cyc;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int ncyc = 0, pick_n = 0, place_n = 0, ill_n = 0, pick_cyc = 0, place_cyc = 0;
  int last_pick_fig = -1, last_place_fig = -1;

  always @(negedge clk) begin
    logic e_pk, e_pl, e_h, e_il;
    ncyc++;
    e_pk = (cyc == pick_at);
    e_pl = (cyc == place_at);
    e_il = (cyc == ill_at);
    e_h  = lifted && (cyc >= wait_entry);
    checks++;
    if (pick_piece !== e_pk || moves_req !== e_pk || place_piece !== e_pl ||
        holding !== e_h || illegal !== e_il || turn !== m_turn ||
        move_count !== 10'(m_cnt) || src_pos !== m_src || figure_position !== m_fig) begin
      errors++;
      $display("FAIL scoreboard t=%0t got pk%b mr%b pl%b h%b il%b turn%b cnt%0d src%0d fig%0d expected pk%b pl%b h%b il%b turn%b cnt%0d src%0d fig%0d",
               $time, pick_piece, moves_req, place_piece, holding, illegal, turn, move_count,
               src_pos, figure_position, e_pk, e_pl, e_h, e_il, m_turn, m_cnt, m_src, m_fig);
    end
    if (pick_piece)  begin pick_n++;  pick_cyc  = ncyc; last_pick_fig  = figure_position; end
    if (place_piece) begin place_n++; place_cyc = ncyc; last_place_fig = figure_position; end
    if (illegal) ill_n++;
  end

  // ---------------- move generator stimulus ----------------
  int          gen_delay = 2, gen_cnt = 0;
  bit          gen_never = 0, gen_pending = 0, gen_rand = 0;
  logic [63:0] gen_mask = '0;

  always @(negedge clk) begin
    moves_valid = 1'b0;
    if (moves_req) begin
      gen_pending = !gen_never;
      gen_cnt     = gen_delay;
    end else if (gen_pending) begin
      gen_cnt--;
      if (gen_cnt == 0) begin
        moves_valid    = 1'b1;
        possible_moves = gen_rand ? {$urandom, $urandom} : gen_mask;
        gen_pending    = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_click(input int pos, input int code);
    @(posedge clk); #1;
    click = 1'b1; click_pos = 6'(pos); sq_code = 4'(code);
    @(posedge clk); #1;
    click = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; game_over = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int p0, i0;
    wait_cyc(3);
    rst = 1'b0;
    chk("reset_turn", turn, 0);
    chk("reset_count", move_count, 0);
    chk("reset_fig", figure_position, 0);

    // wrong side click ignored
    p0 = pick_n;
    do_click(8, 7);
    wait_cyc(3);
    chk("wrong_side_no_pick", pick_n, p0);

    // normal white move 52 -> 36
    gen_mask = '0; gen_mask[44] = 1'b1; gen_mask[36] = 1'b1; gen_delay = 2;
    do_click(52, 1);
    wait_cyc(8);
    chk("pick_fig", last_pick_fig, 52);
    chk("holding_after_mask", holding, 1);
    do_click(36, 1);
    wait_cyc(3);
    chk("place_fig", last_place_fig, 36);
    chk("turn_after_move", turn, 1);
    chk("count_after_move", move_count, 1);

    // black reply 12 -> 20
    gen_mask = '0; gen_mask[20] = 1'b1;
    do_click(12, 9);
    wait_cyc(8);
    do_click(20, 0);
    wait_cyc(3);
    chk("black_turn_back", turn, 0);

    // illegal destination then legal
    gen_mask = '0; gen_mask[44] = 1'b1;
    do_click(52, 1);
    wait_cyc(8);
    i0 = ill_n;
    do_click(20, 0);
    wait_cyc(2);
    chk("illegal_pulse", ill_n - i0, 1);
    do_click(44, 0);
    wait_cyc(3);
    chk("place_after_illegal", last_place_fig, 44);
    chk("count_3", move_count, 3);

    // cancel by clicking the source
    gen_mask = '0; gen_mask[49] = 1'b1;
    do_click(57, 8);
    wait_cyc(8);
    do_click(57, 8);
    wait_cyc(3);
    chk("cancel_fig", last_place_fig, 57);
    chk("cancel_turn", turn, 1);
    chk("cancel_count", move_count, 3);

    // watchdog
    gen_never = 1;
    do_click(52, 10);
    wait_cyc(270);
    chk("wdog_latency", place_cyc - pick_cyc, 256);
    chk("wdog_fig", last_place_fig, 52);
    chk("wdog_turn", turn, 1);
    gen_never = 0;

    // game over raised while holding
    do_reset();
    gen_mask = '0; gen_mask[36] = 1'b1;
    do_click(52, 1);
    wait_cyc(8);
    game_over = 1'b1;
    p0 = place_n;
    do_click(36, 0);
    wait_cyc(4);
    chk("over_place", place_n - p0, 1);
    chk("over_count", move_count, 1);
    p0 = pick_n;
    do_click(12, 9);
    do_click(52, 1);
    wait_cyc(3);
    chk("over_no_pick", pick_n, p0);
    do_reset();
    chk("over_reset_turn", turn, 0);

    // randomized play
    gen_rand = 1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      gen_delay = $urandom_range(1, 6);
      gen_never = ($urandom_range(0, 60) == 0);
      click     = ($urandom_range(0, 3) == 0);
      click_pos = ($urandom_range(0, 3) == 0) ? m_src : 6'($urandom_range(0, 63));
      sq_code   = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 700) == 0) game_over = 1'b1;
      if ($urandom_range(0, 500) == 0) begin
        click = 1'b0;
        do_reset();
      end
    end
    click = 1'b0;
    wait_cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
